// File: rtl/dex_pkg.sv
// dex_pkg: shared definitions for the DEX issue controller.
//   - default parameter constants for the operand, register-address, WAIT
//     counter and write-back port dimensions
//   - issue FSM state type
package dex_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned RADDR_W_DEF  = 5;
    localparam int unsigned WAIT_W_DEF   = 11;
    localparam int unsigned WB_PORTS_DEF = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_VPU  = 2'd2
    } state_t;

endpackage

// File: rtl/dex_fwd_mux.sv
// dex_fwd_mux: write-back forwarding for a single source operand.
//   rs_addr  : source register address
//   rf_data  : register-file read data for that source
//   wb_we    : per-port write-back enables (port 0 in bit 0)
//   wb_addr  : packed per-port write-back addresses (port 0 in LSBs)
//   wb_data  : packed per-port write-back data (port 0 in LSBs)
//   operand  : forwarded operand (purely combinational)
module dex_fwd_mux
    import dex_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RADDR_W  = RADDR_W_DEF,
    parameter int unsigned WB_PORTS = WB_PORTS_DEF
) (
    input  logic [RADDR_W-1:0]          rs_addr,
    input  logic [DATA_W-1:0]           rf_data,
    input  logic [WB_PORTS-1:0]         wb_we,
    input  logic [WB_PORTS*RADDR_W-1:0] wb_addr,
    input  logic [WB_PORTS*DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]           operand
);

    logic hit;

    // Lowest-index matching port wins; later matches are ignored once hit.
    always_comb begin
        operand = rf_data;
        hit     = 1'b0;
        for (int unsigned i = 0; i < WB_PORTS; i++) begin
            if (!hit && wb_we[i] && (wb_addr[i*RADDR_W +: RADDR_W] == rs_addr)) begin
                operand = wb_data[i*DATA_W +: DATA_W];
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dex_issue_ctrl.sv
// dex_issue_ctrl: issue control between ID and the DEX pipeline register.
//   clk, rst_n            : clock, synchronous active-low reset
//   id_*                  : decoded instruction from ID (operands, dst, class)
//   vpu_rdy               : VPU completion
//   wb_we/wb_addr/wb_data : write-back ports used for operand forwarding
//   stall                 : freeze fetch and ID
//   vpu_start             : one-cycle VPU launch pulse
//   dex_*                 : DEX pipeline register contents
// Handles load-use bubbles, multi-cycle WAIT and VPU-blocking instructions.
module dex_issue_ctrl
    import dex_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RADDR_W  = RADDR_W_DEF,
    parameter int unsigned WAIT_W   = WAIT_W_DEF,
    parameter int unsigned WB_PORTS = WB_PORTS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [RADDR_W-1:0]          id_rs0_addr,
    input  logic [RADDR_W-1:0]          id_rs1_addr,
    input  logic                        id_rs0_rd,
    input  logic                        id_rs1_rd,
    input  logic [DATA_W-1:0]           id_rs0_data,
    input  logic [DATA_W-1:0]           id_rs1_data,
    input  logic [RADDR_W-1:0]          id_dst_addr,
    input  logic                        id_dst_we,
    input  logic                        id_is_load,
    input  logic                        id_is_wait,
    input  logic                        id_is_vpu,
    input  logic [WAIT_W-1:0]           id_wait_cnt,
    input  logic                        vpu_rdy,
    input  logic [WB_PORTS-1:0]         wb_we,
    input  logic [WB_PORTS*RADDR_W-1:0] wb_addr,
    input  logic [WB_PORTS*DATA_W-1:0]  wb_data,
    output logic                        stall,
    output logic                        vpu_start,
    output logic                        dex_valid,
    output logic                        dex_dst_we,
    output logic                        dex_is_load,
    output logic [RADDR_W-1:0]          dex_dst_addr,
    output logic [DATA_W-1:0]           dex_op0,
    output logic [DATA_W-1:0]           dex_op1
);

    localparam logic [WAIT_W-1:0] CNT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0]  fwd_op0;
    logic [DATA_W-1:0]  fwd_op1;
    logic               hazard;
    logic               wait_go;
    logic               vpu_go;

    dex_fwd_mux #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .WB_PORTS (WB_PORTS)
    ) u_fwd0 (
        .rs_addr (id_rs0_addr),
        .rf_data (id_rs0_data),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .operand (fwd_op0)
    );

    dex_fwd_mux #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .WB_PORTS (WB_PORTS)
    ) u_fwd1 (
        .rs_addr (id_rs1_addr),
        .rf_data (id_rs1_data),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .operand (fwd_op1)
    );

    assign hazard = id_valid & dex_valid & dex_is_load & dex_dst_we &
                    ((id_rs0_rd & (id_rs0_addr == dex_dst_addr)) |
                     (id_rs1_rd & (id_rs1_addr == dex_dst_addr)));

    // A zero-count WAIT never enters the WAIT state, so it retires as a NOP.
    assign wait_go = id_valid & id_is_wait & (id_wait_cnt != '0) & ~hazard;
    assign vpu_go  = id_valid & id_is_vpu & ~hazard;

    // The launch cycle in RUN counts as the first stall cycle; WAIT drops
    // stall on its counter==0 cycle so the total is exactly id_wait_cnt and
    // the instruction enters DEX on that cycle.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        vpu_start = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                end else if (wait_go) begin
                    stall     = 1'b1;
                    state_nxt = ST_WAIT;
                end else if (vpu_go) begin
                    stall     = 1'b1;
                    vpu_start = 1'b1;
                    state_nxt = ST_VPU;
                end
            end
            ST_WAIT: begin
                if (wait_cnt != '0) begin
                    stall = 1'b1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_VPU: begin
                if (vpu_rdy) begin
                    state_nxt = ST_RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            dex_valid    <= 1'b0;
            dex_dst_we   <= 1'b0;
            dex_is_load  <= 1'b0;
            dex_dst_addr <= '0;
            dex_op0      <= '0;
            dex_op1      <= '0;
        end else begin
            state <= state_nxt;

            if ((state == ST_RUN) && wait_go) begin
                wait_cnt <= id_wait_cnt - CNT_ONE;
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_ONE;
            end

            if (stall) begin
                dex_valid   <= 1'b0;
                dex_dst_we  <= 1'b0;
                dex_is_load <= 1'b0;
            end else begin
                dex_valid    <= id_valid;
                dex_dst_we   <= id_dst_we & id_valid;
                dex_is_load  <= id_is_load & id_valid;
                dex_dst_addr <= id_dst_addr;
                dex_op0      <= fwd_op0;
                dex_op1      <= fwd_op1;
            end
        end
    end

endmodule

// File: tb/tb_dex_issue_ctrl.sv
// Testbench for dex_issue_ctrl: directed vectors with literal expectations,
// plus a cycle-by-cycle comparison against an instruction-level model.
module tb_dex_issue_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;
    localparam int unsigned WW = 11;
    localparam int unsigned NP = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid;
    logic [AW-1:0]     id_rs0_addr, id_rs1_addr;
    logic              id_rs0_rd, id_rs1_rd;
    logic [DW-1:0]     id_rs0_data, id_rs1_data;
    logic [AW-1:0]     id_dst_addr;
    logic              id_dst_we;
    logic              id_is_load, id_is_wait, id_is_vpu;
    logic [WW-1:0]     id_wait_cnt;
    logic              vpu_rdy;
    logic [NP-1:0]     wb_we;
    logic [NP*AW-1:0]  wb_addr;
    logic [NP*DW-1:0]  wb_data;
    logic              stall, vpu_start;
    logic              dex_valid, dex_dst_we, dex_is_load;
    logic [AW-1:0]     dex_dst_addr;
    logic [DW-1:0]     dex_op0, dex_op1;

    always #5 clk = ~clk;

    dex_issue_ctrl #(
        .DATA_W   (DW),
        .RADDR_W  (AW),
        .WAIT_W   (WW),
        .WB_PORTS (NP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs0_addr  (id_rs0_addr),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs0_rd    (id_rs0_rd),
        .id_rs1_rd    (id_rs1_rd),
        .id_rs0_data  (id_rs0_data),
        .id_rs1_data  (id_rs1_data),
        .id_dst_addr  (id_dst_addr),
        .id_dst_we    (id_dst_we),
        .id_is_load   (id_is_load),
        .id_is_wait   (id_is_wait),
        .id_is_vpu    (id_is_vpu),
        .id_wait_cnt  (id_wait_cnt),
        .vpu_rdy      (vpu_rdy),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .stall        (stall),
        .vpu_start    (vpu_start),
        .dex_valid    (dex_valid),
        .dex_dst_we   (dex_dst_we),
        .dex_is_load  (dex_is_load),
        .dex_dst_addr (dex_dst_addr),
        .dex_op0      (dex_op0),
        .dex_op1      (dex_op1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    bit            armed = 0;
    bit            m_valid, m_we, m_load;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_op0, m_op1;
    bit            m_wait_busy;   // a WAIT is holding ID
    int            m_wait_owed;   // stall cycles the WAIT still owes
    bit            m_vpu_busy;    // a VPU op is holding ID, waiting for vpu_rdy

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        logic [DW-1:0] r;
        r = rf;
        // Scan from the highest port down so the lowest matching port is the one left.
        for (int p = NP - 1; p >= 0; p--)
            if (wb_we[p] && wb_addr[p*AW +: AW] == a) r = wb_data[p*DW +: DW];
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_load = 0; m_addr = '0; m_op0 = '0; m_op1 = '0;
        m_wait_busy = 0; m_wait_owed = 0; m_vpu_busy = 0;
    endtask

    always @(negedge clk) begin : compare
        bit haz, e_stall, e_start;
        if (armed) begin
            haz = id_valid && m_valid && m_load && m_we &&
                  ((id_rs0_rd && id_rs0_addr == m_addr) || (id_rs1_rd && id_rs1_addr == m_addr));
            e_start = 0;
            if (m_wait_busy)      e_stall = (m_wait_owed > 0);
            else if (m_vpu_busy)  e_stall = !vpu_rdy;
            else begin
                e_stall = haz || (id_valid && id_is_wait && id_wait_cnt != 0) || (id_valid && id_is_vpu);
                e_start = !haz && id_valid && id_is_vpu;
            end
            check("m_stall",     32'(stall),       32'(e_stall));
            check("m_vpu_start", 32'(vpu_start),   32'(e_start));
            check("m_dex_valid", 32'(dex_valid),   32'(m_valid));
            check("m_dex_we",    32'(dex_dst_we),  32'(m_we));
            check("m_dex_load",  32'(dex_is_load), 32'(m_load));
            if (m_valid) begin
                check("m_dex_addr", 32'(dex_dst_addr), 32'(m_addr));
                check("m_dex_op0",  32'(dex_op0),      32'(m_op0));
                check("m_dex_op1",  32'(dex_op1),      32'(m_op1));
            end
            // advance the model across the coming rising edge
            if (!rst_n) model_reset();
            else begin
                if (m_wait_busy) begin
                    if (m_wait_owed > 0) m_wait_owed--;
                    else m_wait_busy = 0;
                end else if (m_vpu_busy) begin
                    if (vpu_rdy) m_vpu_busy = 0;
                end else if (!haz && id_valid && id_is_wait && id_wait_cnt != 0) begin
                    m_wait_busy = 1;
                    m_wait_owed = int'(id_wait_cnt) - 1;
                end else if (!haz && id_valid && id_is_vpu) begin
                    m_vpu_busy = 1;
                end
                if (e_stall) begin
                    m_valid = 0; m_we = 0; m_load = 0;
                end else begin
                    m_valid = id_valid;
                    m_we    = id_valid && id_dst_we;
                    m_load  = id_valid && id_is_load;
                    m_addr  = id_dst_addr;
                    m_op0   = fwd(id_rs0_addr, id_rs0_data);
                    m_op1   = fwd(id_rs1_addr, id_rs1_data);
                end
            end
        end else if (!rst_n) begin
            model_reset();
            armed = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_rs0_addr = '0; id_rs1_addr = '0; id_rs0_rd = 0; id_rs1_rd = 0;
        id_rs0_data = '0; id_rs1_data = '0; id_dst_addr = '0; id_dst_we = 0;
        id_is_load = 0; id_is_wait = 0; id_is_vpu = 0; id_wait_cnt = '0; wb_we = '0;
    endtask

    task automatic alu(input logic [AW-1:0] dst, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit ld);
        idle_id();
        id_valid = 1; id_dst_addr = dst; id_dst_we = 1; id_is_load = ld;
        id_rs0_addr = a0; id_rs0_data = d0; id_rs0_rd = 1;
        id_rs1_addr = a1; id_rs1_data = d1; id_rs1_rd = 1;
    endtask

    task automatic wait_instr(input logic [WW-1:0] cnt);
        idle_id();
        id_valid = 1; id_is_wait = 1; id_wait_cnt = cnt;
    endtask

    task automatic vpu_instr();
        idle_id();
        id_valid = 1; id_is_vpu = 1; id_dst_addr = 5'd20; id_dst_we = 1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed vectors ----------------
    initial begin : stim
        int n, starts;
        bit done;
        idle_id();
        vpu_rdy = 0; wb_addr = '0; wb_data = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_dex_valid", 32'(dex_valid), 32'd0);
        check("rst_stall",     32'(stall),     32'd0);
        check("rst_vpu_start", 32'(vpu_start), 32'd0);
        tick();

        // forwarding: both ports hit R5, port 0 wins
        alu(5'd9, 5'd5, 16'hAAAA, 5'd7, 16'h0707, 0);
        wb_we = 2'b11; wb_addr = {5'd5, 5'd5}; wb_data = {16'h2222, 16'h1111};
        tick();
        // only port 1 enabled, hits R7
        alu(5'd10, 5'd7, 16'h0101, 5'd6, 16'h0606, 0);
        wb_we = 2'b10; wb_addr = {5'd7, 5'd7}; wb_data = {16'h3333, 16'h1111};
        @(negedge clk);
        check("fwd_both_op0", 32'(dex_op0), 32'h1111);
        check("fwd_both_op1", 32'(dex_op1), 32'h0707);
        tick();

        // load-use on R3
        alu(5'd3, 5'd1, 16'h0011, 5'd2, 16'h0022, 1);
        @(negedge clk);
        check("fwd_p1_op0", 32'(dex_op0), 32'h3333);
        check("fwd_p1_op1", 32'(dex_op1), 32'h0606);
        tick();
        alu(5'd11, 5'd8, 16'h0808, 5'd3, 16'h4444, 0);
        @(negedge clk);
        check("lu_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("lu_bubble", 32'(dex_valid), 32'd0);
        check("lu_resume", 32'(stall),     32'd0);
        tick();
        alu(5'd4, 5'd1, 16'h0001, 5'd2, 16'h0002, 1);
        @(negedge clk);
        check("lu_captured_valid", 32'(dex_valid), 32'd1);
        check("lu_captured_op1",   32'(dex_op1),   32'h4444);
        tick();
        // R4 present but not actually read: no hazard
        alu(5'd12, 5'd4, 16'h1234, 5'd4, 16'h5678, 0);
        id_rs0_rd = 0; id_rs1_rd = 0;
        @(negedge clk);
        check("lu_not_read", 32'(stall), 32'd0);
        tick();

        // WAIT 3
        wait_instr(11'd3);
        n = 0; done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (stall) n++; else done = 1;
            tick();
        end
        idle_id();
        check("wait3_stalls", 32'(n), 32'd3);
        @(negedge clk);
        check("wait3_retire", 32'(dex_valid), 32'd1);
        tick();

        // WAIT 0
        wait_instr(11'd0);
        @(negedge clk);
        check("wait0_stall", 32'(stall), 32'd0);
        tick();
        idle_id();
        @(negedge clk);
        check("wait0_retire", 32'(dex_valid), 32'd1);
        tick();

        // VPU: vpu_rdy high on the launch cycle, then low 5 cycles, then high
        vpu_instr();
        vpu_rdy = 1;
        n = 0; starts = 0;
        @(negedge clk);
        n += int'(stall); starts += int'(vpu_start);
        tick();
        for (int k = 1; k <= 6; k++) begin
            vpu_rdy = (k == 6);
            @(negedge clk);
            n += int'(stall); starts += int'(vpu_start);
            tick();
        end
        idle_id();
        vpu_rdy = 0;
        check("vpu_stalls", 32'(n),      32'd6);
        check("vpu_pulses", 32'(starts), 32'd1);
        @(negedge clk);
        check("vpu_retire", 32'(dex_valid), 32'd1);
        tick();

        // load-use coincident with WAIT 2 in ID
        alu(5'd2, 5'd1, 16'h0001, 5'd1, 16'h0001, 1);
        tick();
        wait_instr(11'd2);
        id_rs0_rd = 1; id_rs0_addr = 5'd2;
        @(negedge clk);
        check("lw_hazard_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("lw_bubble",     32'(dex_valid), 32'd0);
        check("lw_wait_start", 32'(stall),     32'd1);
        tick();
        @(negedge clk);
        check("lw_wait_hold", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("lw_wait_done", 32'(stall), 32'd0);
        tick();
        idle_id();
        @(negedge clk);
        check("lw_retire", 32'(dex_valid), 32'd1);
        tick();

        // reset while WAIT has 2 cycles remaining
        wait_instr(11'd5);
        tick(); tick(); tick();
        rst_n = 0;
        idle_id();
        tick();
        rst_n = 1;
        @(negedge clk);
        check("rw_valid", 32'(dex_valid), 32'd0);
        check("rw_stall", 32'(stall),     32'd0);
        tick();
        vpu_instr();
        @(negedge clk);
        check("rw_run_launch", 32'(vpu_start), 32'd1);
        tick();
        // reset while in VPU with vpu_rdy high
        rst_n = 0; vpu_rdy = 1;
        idle_id();
        tick();
        rst_n = 1; vpu_rdy = 0;
        @(negedge clk);
        check("rv_valid", 32'(dex_valid), 32'd0);
        check("rv_start", 32'(vpu_start), 32'd0);
        check("rv_stall", 32'(stall),     32'd0);
        tick();

        // mixed traffic on a small register set so hazards and forwarding collide
        for (int i = 0; i < 60; i++) begin
            alu(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom),
                5'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)));
            id_rs0_rd = 1'($urandom_range(0, 1));
            id_rs1_rd = 1'($urandom_range(0, 1));
            id_valid  = ($urandom_range(0, 7) != 0);
            id_dst_we = 1'($urandom_range(0, 1));
            wb_we     = 2'($urandom);
            wb_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            wb_data   = {16'($urandom), 16'($urandom)};
            tick();
        end
        idle_id();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
